// File: rtl/mdic_mdio_master.sv
// MDIO clause-22 management frame engine for the MDIC register block.
// One read/write command per start pulse; generates MDC and the serial frame
// (preamble, ST, OP, PHYAD, REGAD, TA, DATA) and returns read data with a
// sticky ready flag and an error flag.
module mdic_mdio_master #(
    parameter int CLK_DIV      = 16,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        ready,
    output logic        error,
    output logic [15:0] rdata,
    output logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [8:0] CNT_LAST = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0] CNT_HALF = 9'(CLK_DIV - 1);
    localparam logic [5:0] PRE_LAST = 6'((PREAMBLE_LEN > 0) ? (PREAMBLE_LEN - 1) : 0);
    localparam bit         HAS_PRE  = (PREAMBLE_LEN > 0);

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [5:0]  bitCnt_q, bitCnt_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  phy_q, phy_d;
    logic [4:0]  regAddr_q, regAddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] shift_q, shift_d;
    logic        taErr_q, taErr_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        error_q, error_d;
    logic [15:0] rdata_q, rdata_d;
    logic        mdc_q, mdc_d;
    logic        mdioOut_q, mdioOut_d;
    logic        mdioOe_q, mdioOe_d;

    logic        isRead;
    logic [5:0]  fieldLast;
    state_t      fieldNext;
    state_t      advState;
    logic [5:0]  advBit;
    logic        advOut;
    logic        advOe;

    assign isRead  = (op_q == 2'b10);
    assign busy    = busy_q;
    assign ready   = ready_q;
    assign error   = error_q;
    assign rdata   = rdata_q;
    assign mdc     = mdc_q;
    assign mdio_o  = mdioOut_q;
    assign mdio_oe = mdioOe_q;

    // Length of the current field and the field that follows it.
    always_comb begin
        fieldLast = 6'd0;
        fieldNext = S_IDLE;
        case (state_q)
            S_PRE:   begin fieldLast = PRE_LAST; fieldNext = S_ST;    end
            S_ST:    begin fieldLast = 6'd1;     fieldNext = S_OP;    end
            S_OP:    begin fieldLast = 6'd1;     fieldNext = S_PHYAD; end
            S_PHYAD: begin fieldLast = 6'd4;     fieldNext = S_REGAD; end
            S_REGAD: begin fieldLast = 6'd4;     fieldNext = S_TA;    end
            S_TA:    begin fieldLast = 6'd1;     fieldNext = S_DATA;  end
            S_DATA:  begin fieldLast = 6'd15;    fieldNext = S_DONE;  end
            default: begin fieldLast = 6'd0;     fieldNext = S_IDLE;  end
        endcase
    end

    // Position of the next bit and the MDIO drive value/enable it needs.
    always_comb begin
        if (bitCnt_q == fieldLast) begin
            advState = fieldNext;
            advBit   = 6'd0;
        end else begin
            advState = state_q;
            advBit   = bitCnt_q + 6'd1;
        end
        advOut = 1'b1;
        advOe  = 1'b1;
        case (advState)
            S_PRE:   advOut = 1'b1;
            S_ST:    advOut = advBit[0];
            S_OP:    advOut = op_q[~advBit[0]];
            S_PHYAD: advOut = phy_q[3'd4 - advBit[2:0]];
            S_REGAD: advOut = regAddr_q[3'd4 - advBit[2:0]];
            S_TA: begin
                if (isRead) begin
                    advOe  = 1'b0;
                    advOut = 1'b1;
                end else begin
                    advOut = ~advBit[0];
                end
            end
            S_DATA: begin
                if (isRead) begin
                    advOe  = 1'b0;
                    advOut = 1'b1;
                end else begin
                    advOut = wdata_q[4'd15 - advBit[3:0]];
                end
            end
            default: begin
                advOut = 1'b1;
                advOe  = 1'b0;
            end
        endcase
    end

    // Next-state logic: command capture, MDC divider, bit sequencing and read sampling.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitCnt_d  = bitCnt_q;
        op_d      = op_q;
        phy_d     = phy_q;
        regAddr_d = regAddr_q;
        wdata_d   = wdata_q;
        shift_d   = shift_q;
        taErr_d   = taErr_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        error_d   = error_q;
        rdata_d   = rdata_q;
        mdc_d     = mdc_q;
        mdioOut_d = mdioOut_q;
        mdioOe_d  = mdioOe_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d      = op;
                    phy_d     = phy_addr;
                    regAddr_d = reg_addr;
                    wdata_d   = wdata;
                    if (op == 2'b01 || op == 2'b10) begin
                        state_d   = HAS_PRE ? S_PRE : S_ST;
                        cnt_d     = 9'd0;
                        bitCnt_d  = 6'd0;
                        taErr_d   = 1'b0;
                        busy_d    = 1'b1;
                        ready_d   = 1'b0;
                        error_d   = 1'b0;
                        mdc_d     = 1'b0;
                        mdioOe_d  = 1'b1;
                        mdioOut_d = HAS_PRE;
                    end else begin
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        error_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = 9'd0;
                    mdc_d = 1'b0;
                    if (isRead && state_q == S_TA && bitCnt_q == 6'd1) begin
                        taErr_d = mdio_i;
                    end
                    if (isRead && state_q == S_DATA) begin
                        shift_d = {shift_q[14:0], mdio_i};
                    end
                    if (advState == S_DONE) begin
                        state_d   = S_DONE;
                        busy_d    = 1'b0;
                        ready_d   = 1'b1;
                        mdioOe_d  = 1'b0;
                        mdioOut_d = 1'b1;
                        if (isRead) begin
                            rdata_d = {shift_q[14:0], mdio_i};
                            error_d = taErr_q;
                        end
                    end else begin
                        state_d   = advState;
                        bitCnt_d  = advBit;
                        mdioOut_d = advOut;
                        mdioOe_d  = advOe;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                    if (cnt_q == CNT_HALF) begin
                        mdc_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // State and output registers; reset aborts any frame immediately.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= 9'd0;
            bitCnt_q  <= 6'd0;
            op_q      <= 2'b00;
            phy_q     <= 5'd0;
            regAddr_q <= 5'd0;
            wdata_q   <= 16'h0;
            shift_q   <= 16'h0;
            taErr_q   <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            rdata_q   <= 16'h0;
            mdc_q     <= 1'b0;
            mdioOut_q <= 1'b1;
            mdioOe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitCnt_q  <= bitCnt_d;
            op_q      <= op_d;
            phy_q     <= phy_d;
            regAddr_q <= regAddr_d;
            wdata_q   <= wdata_d;
            shift_q   <= shift_d;
            taErr_q   <= taErr_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            rdata_q   <= rdata_d;
            mdc_q     <= mdc_d;
            mdioOut_q <= mdioOut_d;
            mdioOe_q  <= mdioOe_d;
        end
    end

endmodule

// File: tb/tb_mdic_mdio_master.sv
// Testbench for mdic_mdio_master: write/read frames, missing PHY, ignored
// mid-frame start, back-to-back commands, bad op and mid-frame reset.
module tb_mdic_mdio_master;

    localparam int D         = 2;
    localparam int PL        = 32;
    localparam int N         = PL + 32;
    localparam int READY_CYC = 2 * D * N + 1;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  phy_addr;
    logic [4:0]  reg_addr;
    logic [15:0] wdata;
    logic        busy;
    logic        ready;
    logic        error;
    logic [15:0] rdata;
    logic        mdc;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_oe;
    logic        phyLine;

    int checks;
    int failures;

    typedef struct {
        logic [63:0] bits;
        logic [63:0] mask;
        logic [63:0] oe;
        logic [15:0] rdata;
        logic        err;
        int          readyCyc;
    } exp_t;

    exp_t        scoreQ[$];
    logic [15:0] modelRdata;

    logic [63:0] obsBits;
    logic [63:0] obsOe;
    int          obsReady;
    int          obsMdcErr;
    int          obsBusyErr;
    int          obsRises;

    mdic_mdio_master #(.CLK_DIV(D), .PREAMBLE_LEN(PL)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .start    (start),
        .op       (op),
        .phy_addr (phy_addr),
        .reg_addr (reg_addr),
        .wdata    (wdata),
        .busy     (busy),
        .ready    (ready),
        .error    (error),
        .rdata    (rdata),
        .mdc      (mdc),
        .mdio_i   (mdio_i),
        .mdio_o   (mdio_o),
        .mdio_oe  (mdio_oe)
    );

    // Shared MDIO line: master when enabled, otherwise PHY model with pull-up.
    assign mdio_i = mdio_oe ? mdio_o : phyLine;

    // Free-running clock.
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    function automatic exp_t makeExp(input logic [1:0] o, input logic [4:0] p, input logic [4:0] rg,
                                     input logic [15:0] dat, input bit present, input logic [15:0] phyData,
                                     input logic [15:0] prevRdata);
        exp_t e;
        if (o == 2'b01) begin
            e.bits  = {32'hFFFF_FFFF, 2'b01, o, p, rg, 2'b10, dat};
            e.mask  = '1;
            e.oe    = '1;
            e.rdata = prevRdata;
            e.err   = 1'b0;
        end else begin
            e.bits  = {32'hFFFF_FFFF, 2'b01, o, p, rg, 18'h0};
            e.mask  = {46'h3FFF_FFFF_FFFF, 18'h0};
            e.oe    = {46'h3FFF_FFFF_FFFF, 18'h0};
            e.rdata = present ? phyData : 16'hFFFF;
            e.err   = !present;
        end
        e.readyCyc = READY_CYC;
        return e;
    endfunction

    function automatic logic phyBit(input int r, input bit present, input logic [15:0] d);
        if (!present) return 1'b1;
        if (r == N - 17) return 1'b0;
        if (r >= N - 16) return d[15 - (r - (N - 16))];
        return 1'b1;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [4:0] p, input logic [4:0] rg, input logic [15:0] dat);
        @(posedge aclk);
        #1;
        start    = 1'b1;
        op       = o;
        phy_addr = p;
        reg_addr = rg;
        wdata    = dat;
        @(posedge aclk);
        #1;
        start = 1'b0;
    endtask

    // Called in cycle 1 of a frame; observes until ready, an abort point or the cycle budget.
    task automatic runFrame(input bit present, input logic [15:0] phyData, input int injectAt, input int abortRise);
        int   c;
        int   r;
        logic prevMdc;
        logic expMdc;
        obsBits    = '0;
        obsOe      = '0;
        obsReady   = 0;
        obsMdcErr  = 0;
        obsBusyErr = 0;
        r          = 0;
        c          = 1;
        prevMdc    = 1'b0;
        while (c <= READY_CYC + 20) begin
            if (injectAt != 0 && c == injectAt) begin
                start    = 1'b1;
                op       = 2'b10;
                phy_addr = 5'h1F;
                reg_addr = 5'h1F;
                wdata    = 16'h1234;
            end else if (injectAt != 0 && c == injectAt + 1) begin
                start = 1'b0;
            end
            if (ready === 1'b1) begin
                obsReady = c;
                break;
            end
            if (c <= 2 * D * N) begin
                expMdc = (((c - 1) % (2 * D)) >= D);
                if (mdc !== expMdc) obsMdcErr++;
                if (busy !== 1'b1) obsBusyErr++;
            end
            if (mdc === 1'b1 && prevMdc === 1'b0 && r < 64) begin
                obsBits[63 - r] = mdio_o;
                obsOe[63 - r]   = mdio_oe;
                phyLine         = phyBit(r, present, phyData);
                r++;
                if (r == abortRise) begin
                    obsRises = r;
                    return;
                end
            end
            prevMdc = mdc;
            @(posedge aclk);
            #1;
            c++;
        end
        obsRises = r;
        phyLine  = 1'b1;
    endtask

    task automatic test_reset();
        aresetn  = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        phy_addr = 5'd0;
        reg_addr = 5'd0;
        wdata    = 16'h0;
        phyLine  = 1'b1;
        #12;
        checks++;
        if ({busy, ready, error, mdc, mdio_o, mdio_oe} !== 6'b000010) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b expected %b", {busy, ready, error, mdc, mdio_o, mdio_oe}, 6'b000010);
        end
        checks++;
        if (rdata !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_rdata: got %h expected %h", rdata, 16'h0);
        end
        #10;
        aresetn = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({busy, ready, error, mdc, mdio_o, mdio_oe} !== 6'b000010) begin
            failures++;
            $display("[TB] FAIL idle_after_reset: got %b expected %b", {busy, ready, error, mdc, mdio_o, mdio_oe}, 6'b000010);
        end
    endtask

    task automatic test_write();
        exp_t e;
        scoreQ.push_back(makeExp(2'b01, 5'd0, 5'd1, 16'hAA55, 1'b0, 16'h0, modelRdata));
        issue(2'b01, 5'd0, 5'd1, 16'hAA55);
        checks++;
        if ({busy, ready, error} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL write_cycle1: got %b expected %b", {busy, ready, error}, 3'b100);
        end
        runFrame(1'b0, 16'h0, 0, 0);
        e = scoreQ.pop_front();
        checks++;
        if (obsBits !== e.bits) begin
            failures++;
            $display("[TB] FAIL write_bits: got %h expected %h", obsBits, e.bits);
        end
        checks++;
        if (obsOe !== e.oe) begin
            failures++;
            $display("[TB] FAIL write_oe: got %h expected %h", obsOe, e.oe);
        end
        checks++;
        if (obsReady !== e.readyCyc) begin
            failures++;
            $display("[TB] FAIL write_ready_cycle: got %0d expected %0d", obsReady, e.readyCyc);
        end
        checks++;
        if ({error, rdata} !== {e.err, e.rdata}) begin
            failures++;
            $display("[TB] FAIL write_err_rdata: got %b/%h expected %b/%h", error, rdata, e.err, e.rdata);
        end
        checks++;
        if (obsMdcErr + obsBusyErr !== 0) begin
            failures++;
            $display("[TB] FAIL write_mdc_busy: got %0d bad cycles expected 0", obsMdcErr + obsBusyErr);
        end
        checks++;
        if ({busy, mdc, mdio_oe, mdio_o} !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL write_done_outputs: got %b expected %b", {busy, mdc, mdio_oe, mdio_o}, 4'b0001);
        end
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ready_sticky: got %b expected %b", ready, 1'b1);
        end
    endtask

    task automatic test_read(input logic [4:0] p, input logic [4:0] rg, input logic [15:0] phyData, input bit present);
        exp_t e;
        scoreQ.push_back(makeExp(2'b10, p, rg, 16'h0, present, phyData, modelRdata));
        issue(2'b10, p, rg, 16'h0);
        runFrame(present, phyData, 0, 0);
        e = scoreQ.pop_front();
        modelRdata = e.rdata;
        checks++;
        if ((obsBits & e.mask) !== e.bits) begin
            failures++;
            $display("[TB] FAIL read_header_bits: got %h expected %h", obsBits & e.mask, e.bits);
        end
        checks++;
        if (obsOe !== e.oe) begin
            failures++;
            $display("[TB] FAIL read_oe: got %h expected %h", obsOe, e.oe);
        end
        checks++;
        if (obsReady !== e.readyCyc) begin
            failures++;
            $display("[TB] FAIL read_ready_cycle: got %0d expected %0d", obsReady, e.readyCyc);
        end
        checks++;
        if (rdata !== e.rdata) begin
            failures++;
            $display("[TB] FAIL read_rdata: got %h expected %h", rdata, e.rdata);
        end
        checks++;
        if (error !== e.err) begin
            failures++;
            $display("[TB] FAIL read_error: got %b expected %b", error, e.err);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        scoreQ.push_back(makeExp(2'b01, 5'd3, 5'd9, 16'h8001, 1'b0, 16'h0, modelRdata));
        issue(2'b01, 5'd3, 5'd9, 16'h8001);
        runFrame(1'b0, 16'h0, 50, 0);
        e = scoreQ.pop_front();
        checks++;
        if (obsBits !== e.bits) begin
            failures++;
            $display("[TB] FAIL ignore_start_bits: got %h expected %h", obsBits, e.bits);
        end
        checks++;
        if (obsReady !== e.readyCyc || obsBusyErr !== 0) begin
            failures++;
            $display("[TB] FAIL ignore_start_timing: got ready %0d busy errs %0d expected %0d / 0", obsReady, obsBusyErr, e.readyCyc);
        end
        checks++;
        if ({error, rdata} !== {e.err, e.rdata}) begin
            failures++;
            $display("[TB] FAIL ignore_start_result: got %b/%h expected %b/%h", error, rdata, e.err, e.rdata);
        end
        scoreQ.push_back(makeExp(2'b10, 5'd2, 5'd4, 16'h0, 1'b1, 16'hC3A5, modelRdata));
        issue(2'b10, 5'd2, 5'd4, 16'h0);
        checks++;
        if ({busy, ready} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL b2b_accept: got %b expected %b", {busy, ready}, 2'b10);
        end
        runFrame(1'b1, 16'hC3A5, 0, 0);
        e = scoreQ.pop_front();
        modelRdata = e.rdata;
        checks++;
        if ({obsReady, error, rdata} !== {e.readyCyc, e.err, e.rdata}) begin
            failures++;
            $display("[TB] FAIL b2b_read: got %0d/%b/%h expected %0d/%b/%h", obsReady, error, rdata, e.readyCyc, e.err, e.rdata);
        end
    endtask

    task automatic test_bad_op();
        int edges;
        logic prev;
        issue(2'b00, 5'd1, 5'd1, 16'hFFFF);
        checks++;
        if ({busy, ready, error} !== 3'b011) begin
            failures++;
            $display("[TB] FAIL bad_op_cycle1: got %b expected %b", {busy, ready, error}, 3'b011);
        end
        edges = 0;
        prev  = mdc;
        for (int i = 0; i < 20; i++) begin
            @(posedge aclk);
            #1;
            if (mdc !== prev || mdio_oe !== 1'b0 || busy !== 1'b0) edges++;
            prev = mdc;
        end
        checks++;
        if (edges !== 0) begin
            failures++;
            $display("[TB] FAIL bad_op_activity: got %0d active cycles expected 0", edges);
        end
        checks++;
        if (rdata !== modelRdata) begin
            failures++;
            $display("[TB] FAIL bad_op_rdata: got %h expected %h", rdata, modelRdata);
        end
        issue(2'b11, 5'd1, 5'd1, 16'h0);
        checks++;
        if ({busy, ready, error} !== 3'b011) begin
            failures++;
            $display("[TB] FAIL bad_op11: got %b expected %b", {busy, ready, error}, 3'b011);
        end
        issue(2'b01, 5'd5, 5'd6, 16'h0F0F);
        checks++;
        if ({busy, ready, error} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL error_cleared: got %b expected %b", {busy, ready, error}, 3'b100);
        end
        runFrame(1'b0, 16'h0, 0, 0);
        checks++;
        if ({obsReady, error} !== {READY_CYC, 1'b0}) begin
            failures++;
            $display("[TB] FAIL after_bad_op_frame: got %0d/%b expected %0d/%b", obsReady, error, READY_CYC, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        issue(2'b10, 5'd7, 5'd2, 16'h0);
        runFrame(1'b1, 16'h0F0F, 0, 39);
        checks++;
        if (obsRises !== 39 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_phyad_reach: got %0d rises busy %b expected 39 busy 1", obsRises, busy);
        end
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if ({mdc, mdio_oe, busy, ready, mdio_o} !== 5'b00001) begin
            failures++;
            $display("[TB] FAIL async_reset: got %b expected %b", {mdc, mdio_oe, busy, ready, mdio_o}, 5'b00001);
        end
        phyLine    = 1'b1;
        modelRdata = 16'h0;
        #13;
        aresetn = 1'b1;
        test_read(5'd7, 5'd2, 16'h5A3C, 1'b1);
    endtask

    // Test sequence.
    initial begin
        checks     = 0;
        failures   = 0;
        modelRdata = 16'h0;
        test_reset();
        test_write();
        test_read(5'd0, 5'd0, 16'hABCD, 1'b1);
        test_read(5'd0, 5'd0, 16'h0, 1'b0);
        test_back_to_back();
        test_bad_op();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
